// File: rtl/counter_pkg.sv
// counter_pkg
//   Shared constants and helpers for the up/down modulus counter family.
//   MODE_WRAP / MODE_SAT select the end-of-range behaviour, DIR_UP / DIR_DOWN
//   decode UP_DOWN, and max_count() gives the largest legal count value.
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;

  // Largest count reachable for a given width and modulus. The modulus is
  // clamped to the width's range so a bad parameter cannot produce a terminal
  // value that Q could never hold (the top also refuses such a modulus).
  function automatic longint unsigned max_count(input int unsigned width,
                                                input longint unsigned modulus);
    longint unsigned full_range;
    full_range = 64'd1 << width;
    if (modulus > full_range) begin
      return full_range - 64'd1;
    end else begin
      return modulus - 64'd1;
    end
  endfunction

endpackage

// File: rtl/counter_next.sv
// counter_next
//   Purely combinational next-state logic for updown_mod_counter.
//   Ports:
//     q        in  WIDTH  current count
//     up_down  in  1      1 = count up, 0 = count down
//     mode     in  1      0 = wrap, 1 = saturate
//     en       in  1      count enable
//     q_next   out WIDTH  count after an enabled (or held) edge
//     wrap     out 1      this edge wraps the count
//     tc       out 1      terminal count, gated by en
module counter_next
  import counter_pkg::*;
#(
  parameter int unsigned       WIDTH   = 5,
  parameter longint unsigned   MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_down,
  input  logic             mode,
  input  logic             en,
  output logic [WIDTH-1:0] q_next,
  output logic             wrap,
  output logic             tc
);

  // Compare in WIDTH+1 bits so MODULUS = 2**WIDTH has a representable maximum.
  localparam longint unsigned MAX_L = max_count(WIDTH, MODULUS);
  localparam logic [WIDTH:0]  MAX_C = MAX_L[WIDTH:0];

  logic [WIDTH:0] q_ext_s;
  logic [WIDTH:0] inc_s;
  logic [WIDTH:0] dec_s;
  logic           at_max_s;
  logic           at_zero_s;

  assign q_ext_s   = {1'b0, q};
  assign inc_s     = q_ext_s + {{WIDTH{1'b0}}, 1'b1};
  assign dec_s     = q_ext_s - {{WIDTH{1'b0}}, 1'b1};
  assign at_max_s  = (q_ext_s == MAX_C);
  assign at_zero_s = (q_ext_s == {(WIDTH+1){1'b0}});

  // Terminal count ignores MODE so a saturated stage still signals its end.
  assign tc = en & ((up_down == DIR_UP) ? at_max_s : at_zero_s);

  // Next count and wrap flag; a disabled counter holds and never wraps.
  always_comb begin
    q_next = q;
    wrap   = 1'b0;
    if (en) begin
      if (up_down == DIR_UP) begin
        if (at_max_s) begin
          if (mode == MODE_WRAP) begin
            q_next = {WIDTH{1'b0}};
            wrap   = 1'b1;
          end else begin
            q_next = q;
            wrap   = 1'b0;
          end
        end else begin
          q_next = inc_s[WIDTH-1:0];
        end
      end else begin
        if (at_zero_s) begin
          if (mode == MODE_WRAP) begin
            q_next = MAX_C[WIDTH-1:0];
            wrap   = 1'b1;
          end else begin
            q_next = q;
            wrap   = 1'b0;
          end
        end else begin
          q_next = dec_s[WIDTH-1:0];
        end
      end
    end else begin
      q_next = q;
      wrap   = 1'b0;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// updown_mod_counter
//   Synchronous up/down counter with programmable modulus, wrap/saturate
//   mode, parallel load and a cascade-ready terminal count.
//   Ports:
//     CLK       in  1      clock, rising edge
//     RESET     in  1      synchronous active-high reset, highest priority
//     EN        in  1      count enable / cascade input from lower stage TC
//     UP_DOWN   in  1      1 = up, 0 = down
//     MODE      in  1      0 = wrap, 1 = saturate
//     LOAD      in  1      synchronous parallel load (overrides EN)
//     LOAD_VAL  in  WIDTH  value to load; out-of-range loads clamp to max
//     Q         out WIDTH  registered count
//     TC        out 1      combinational terminal count, feeds next stage EN
//     WRAP      out 1      registered one-cycle wrap pulse
//     LOAD_ERR  out 1      registered one-cycle out-of-range load pulse
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int unsigned     WIDTH   = 5,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP_DOWN,
  input  logic             MODE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             LOAD_ERR
);

  localparam longint unsigned MAX_L = max_count(WIDTH, MODULUS);
  localparam logic [WIDTH:0]  MAX_C = MAX_L[WIDTH:0];

  // Refuse parameter sets the counter cannot represent.
  if (WIDTH < 32'd1 || WIDTH > 32'd32) begin : g_bad_width
    $fatal(1, "updown_mod_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $fatal(1, "updown_mod_counter: MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] q_r;
  logic             wrap_r;
  logic             load_err_r;
  logic [WIDTH-1:0] q_next_s;
  logic             wrap_s;
  logic             tc_s;
  logic             load_ok_s;

  // Widened compare so a full-range modulus does not overflow.
  assign load_ok_s = ({1'b0, LOAD_VAL} <= MAX_C);

  counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q       (q_r),
    .up_down (UP_DOWN),
    .mode    (MODE),
    .en      (EN),
    .q_next  (q_next_s),
    .wrap    (wrap_s),
    .tc      (tc_s)
  );

  // Count register with RESET > LOAD > EN > hold priority; pulses self-clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      q_r        <= {WIDTH{1'b0}};
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end else if (LOAD) begin
      q_r        <= load_ok_s ? LOAD_VAL : MAX_C[WIDTH-1:0];
      wrap_r     <= 1'b0;
      load_err_r <= ~load_ok_s;
    end else if (EN) begin
      q_r        <= q_next_s;
      wrap_r     <= wrap_s;
      load_err_r <= 1'b0;
    end else begin
      q_r        <= q_r;
      wrap_r     <= 1'b0;
      load_err_r <= 1'b0;
    end
  end

  assign Q        = q_r;
  assign TC       = tc_s;
  assign WRAP     = wrap_r;
  assign LOAD_ERR = load_err_r;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb_updown_mod_counter
//   Bench for updown_mod_counter: a decimal (WIDTH=4, MODULUS=10) counter
//   driven from a vector table, a two-stage decimal cascade, and a
//   full-range (MODULUS=16) instance for the wrap at 2**WIDTH.
module tb_updown_mod_counter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       up;
    logic       mode;
    logic       load;
    logic [3:0] lval;
    logic       tc_chk;   // compare TC before the edge
    logic       exp_tc;
    logic [3:0] exp_q;    // after the edge
    logic       exp_wrap;
    logic       exp_lerr;
  } vec_t;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    logic       tens_wrap;
    logic       units_wrap;
  } casc_t;

  logic CLK;
  int   n_vec;
  int   n_miscmp;

  // main decimal counter
  logic       rst, en, up, mode, load;
  logic [3:0] lval;
  logic [3:0] q;
  logic       tc, wrap, lerr;

  // cascade
  logic       c_rst, c_en, c_up;
  logic [3:0] u_q, t_q;
  logic       u_tc, t_tc, u_wrap, t_wrap, u_lerr, t_lerr;

  // full range
  logic       f_rst, f_en, f_load;
  logic [3:0] f_lval, f_q;
  logic       f_tc, f_wrap, f_lerr;

  vec_t  tbl[$];
  vec_t  sb_q[$];
  casc_t csb_q[$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  updown_mod_counter #(.WIDTH(4), .MODULUS(64'd10)) dut (
    .CLK(CLK), .RESET(rst), .EN(en), .UP_DOWN(up), .MODE(mode), .LOAD(load),
    .LOAD_VAL(lval), .Q(q), .TC(tc), .WRAP(wrap), .LOAD_ERR(lerr)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(64'd10)) units (
    .CLK(CLK), .RESET(c_rst), .EN(c_en), .UP_DOWN(c_up), .MODE(L), .LOAD(L),
    .LOAD_VAL(4'd0), .Q(u_q), .TC(u_tc), .WRAP(u_wrap), .LOAD_ERR(u_lerr)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(64'd10)) tens (
    .CLK(CLK), .RESET(c_rst), .EN(u_tc), .UP_DOWN(c_up), .MODE(L), .LOAD(L),
    .LOAD_VAL(4'd0), .Q(t_q), .TC(t_tc), .WRAP(t_wrap), .LOAD_ERR(t_lerr)
  );

  updown_mod_counter #(.WIDTH(4), .MODULUS(64'd16)) full (
    .CLK(CLK), .RESET(f_rst), .EN(f_en), .UP_DOWN(H), .MODE(L), .LOAD(f_load),
    .LOAD_VAL(f_lval), .Q(f_q), .TC(f_tc), .WRAP(f_wrap), .LOAD_ERR(f_lerr)
  );

  function automatic vec_t mk(input logic r, input logic e, input logic u,
                              input logic m, input logic ld, input logic [3:0] lv,
                              input logic tcc, input logic etc,
                              input logic [3:0] eq, input logic ew, input logic el);
    vec_t v;
    v.rst = r; v.en = e; v.up = u; v.mode = m; v.load = ld; v.lval = lv;
    v.tc_chk = tcc; v.exp_tc = etc;
    v.exp_q = eq; v.exp_wrap = ew; v.exp_lerr = el;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_miscmp = n_miscmp + 1;
      $display("FAIL %s[%0d]: got %0h, want %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    vec_t e;
    rst = v.rst; en = v.en; up = v.up; mode = v.mode; load = v.load; lval = v.lval;
    #1;
    if (v.tc_chk) chk("tc", idx, {31'd0, tc}, {31'd0, v.exp_tc});
    sb_q.push_back(v);
    n_vec = n_vec + 1;
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("q", idx, {28'd0, q}, {28'd0, e.exp_q});
    chk("wrap", idx, {31'd0, wrap}, {31'd0, e.exp_wrap});
    chk("load_err", idx, {31'd0, lerr}, {31'd0, e.exp_lerr});
  endtask

  // One cascade step; v is the two-digit value before the edge.
  task automatic casc_step(input logic r, input logic dir_up, input int v, input int idx);
    casc_t e;
    int    nv;
    c_rst = r; c_en = H; c_up = dir_up;
    if (r) begin
      e.tens = 4'd0; e.units = 4'd0; e.tens_wrap = L; e.units_wrap = L;
    end else if (dir_up) begin
      nv = (v + 1) % 100;
      e.tens = 4'(nv / 10); e.units = 4'(nv % 10);
      e.units_wrap = ((v % 10) == 9);
      e.tens_wrap  = (v == 99);
    end else begin
      nv = (v + 99) % 100;
      e.tens = 4'(nv / 10); e.units = 4'(nv % 10);
      e.units_wrap = ((v % 10) == 0);
      e.tens_wrap  = (v == 0);
    end
    csb_q.push_back(e);
    n_vec = n_vec + 1;
    @(posedge CLK);
    #1;
    e = csb_q.pop_front();
    chk("casc_tens", idx, {28'd0, t_q}, {28'd0, e.tens});
    chk("casc_units", idx, {28'd0, u_q}, {28'd0, e.units});
    chk("casc_tens_wrap", idx, {31'd0, t_wrap}, {31'd0, e.tens_wrap});
    chk("casc_units_wrap", idx, {31'd0, u_wrap}, {31'd0, e.units_wrap});
  endtask

  initial begin
    int v;
    n_vec = 0; n_miscmp = 0;
    rst = H; en = L; up = H; mode = L; load = L; lval = 4'd0;
    c_rst = H; c_en = L; c_up = H;
    f_rst = H; f_en = L; f_load = L; f_lval = 4'd0;

    // reset held two cycles with EN=1, then count up
    tbl.push_back(mk(H, H, H, L, L, 4'd0, L, L, 4'd0, L, L));
    tbl.push_back(mk(H, H, H, L, L, 4'd0, H, L, 4'd0, L, L));
    tbl.push_back(mk(L, H, H, L, L, 4'd0, H, L, 4'd1, L, L));
    tbl.push_back(mk(L, H, H, L, L, 4'd0, H, L, 4'd2, L, L));
    // load 0, then 12 enabled up cycles in wrap mode
    tbl.push_back(mk(L, L, H, L, H, 4'd0, H, L, 4'd0, L, L));
    for (int i = 0; i < 12; i++) begin
      tbl.push_back(mk(L, H, H, L, L, 4'd0, H, (i == 9), 4'((i + 1) % 10), (i == 9), L));
    end
    // down saturate from 3
    tbl.push_back(mk(L, L, L, H, H, 4'd3, H, L, 4'd3, L, L));
    for (int j = 0; j < 6; j++) begin
      tbl.push_back(mk(L, H, L, H, L, 4'd0, H, (j >= 3), (j < 3) ? 4'(2 - j) : 4'd0, L, L));
    end
    // down wrap from 0, then hold
    tbl.push_back(mk(L, H, L, L, L, 4'd0, H, H, 4'd9, H, L));
    tbl.push_back(mk(L, L, L, L, L, 4'd0, H, L, 4'd9, L, L));
    // load rules
    tbl.push_back(mk(L, L, H, L, H, 4'd12, H, L, 4'd9, L, H));
    tbl.push_back(mk(L, L, H, L, L, 4'd0,  H, L, 4'd9, L, L));
    tbl.push_back(mk(L, H, H, L, H, 4'd4,  H, H, 4'd4, L, L));
    tbl.push_back(mk(L, H, H, L, H, 4'd15, H, L, 4'd9, L, H));
    tbl.push_back(mk(H, H, H, L, H, 4'd12, H, H, 4'd0, L, L));
    tbl.push_back(mk(L, L, H, L, H, 4'd9,  H, L, 4'd9, L, L));
    tbl.push_back(mk(L, L, H, L, H, 4'd10, H, L, 4'd9, L, H));
    // up saturate holds at 9, then wrap mode wraps
    tbl.push_back(mk(L, H, H, H, L, 4'd0, H, H, 4'd9, L, L));
    tbl.push_back(mk(L, H, H, L, L, 4'd0, H, H, 4'd0, H, L));

    @(posedge CLK);
    #1;
    foreach (tbl[k]) apply_vec(tbl[k], k);

    // two-stage decimal cascade: 25 up, then 26 down through 00 -> 99
    casc_step(H, H, 0, 0);
    v = 0;
    for (int i = 0; i < 25; i++) begin
      casc_step(L, H, v, 100 + i);
      v = (v + 1) % 100;
    end
    chk("casc_after_up", 0, {24'd0, t_q, u_q}, {24'd0, 4'd2, 4'd5});
    for (int i = 0; i < 26; i++) begin
      casc_step(L, L, v, 200 + i);
      v = (v + 99) % 100;
    end
    chk("casc_after_down", 0, {24'd0, t_q, u_q}, {24'd0, 4'd9, 4'd9});
    c_en = L;

    // full-range modulus: 15 -> 0 with a wrap pulse
    f_rst = H;
    @(posedge CLK); #1;
    f_rst = L; f_load = H; f_lval = 4'd15;
    @(posedge CLK); #1;
    n_vec = n_vec + 1;
    chk("full_load_q", 0, {28'd0, f_q}, {28'd0, 4'd15});
    chk("full_load_err", 0, {31'd0, f_lerr}, {31'd0, L});
    f_load = L; f_en = H;
    #1;
    chk("full_tc", 0, {31'd0, f_tc}, {31'd0, H});
    @(posedge CLK); #1;
    n_vec = n_vec + 1;
    chk("full_wrap_q", 0, {28'd0, f_q}, {28'd0, 4'd0});
    chk("full_wrap", 0, {31'd0, f_wrap}, {31'd0, H});
    f_en = L;
    @(posedge CLK); #1;
    n_vec = n_vec + 1;
    chk("full_wrap_clear", 0, {31'd0, f_wrap}, {31'd0, L});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
